// File: rtl/ball_motion_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : ball_motion_scheduler_if
// Description : Frame trigger, control and position read-port bundle of the
//               metaball motion scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
interface ball_motion_scheduler_if;
    logic       v_sync;
    logic       pause;
    logic [2:0] rd_idx;
    logic [9:0] rd_x;
    logic [9:0] rd_y;
    logic       busy;
    logic       frame_done;
    logic       overrun;

    // Master: VGA timing / pixel path. Slave: the scheduler.
    modport master (
        output v_sync, pause, rd_idx,
        input  rd_x, rd_y, busy, frame_done, overrun
    );

    modport slave (
        input  v_sync, pause, rd_idx,
        output rd_x, rd_y, busy, frame_done, overrun
    );
endinterface
`default_nettype wire

// File: rtl/ball_motion_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : ball_motion_scheduler
// Description : Per-frame position/velocity update of NUM_BALLS metaballs
//               through one shared step/bounce datapath, started on v_sync fall.
// Revision    : 1.0 - initial release
// ============================================================================
module ball_motion_scheduler #(
    parameter int NUM_BALLS     = 4,
    parameter int BALL_SPEED    = 5,
    parameter int SCREEN_WIDTH  = 800,
    parameter int SCREEN_HEIGHT = 600,
    parameter int BALL_DIM      = 25
) (
    input  logic                     clk_50mhz,
    input  logic                     reset_n,
    ball_motion_scheduler_if.slave   bus
);

    localparam int IDX_W = (NUM_BALLS > 1) ? $clog2(NUM_BALLS) : 1;
    localparam logic [9:0]       c_speed = 10'(BALL_SPEED);
    localparam logic [9:0]       c_x_max = 10'(SCREEN_WIDTH - BALL_DIM - BALL_SPEED);
    localparam logic [9:0]       c_y_max = 10'(SCREEN_HEIGHT - BALL_DIM - BALL_SPEED);
    localparam logic [IDX_W-1:0] c_last  = IDX_W'(NUM_BALLS - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_STEP  = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] cnt_q, cnt_d;
    logic             v_sync_q;
    logic             overrun_q;
    logic             trig;
    logic             busy_w;
    logic             done_w;

    logic [9:0] x_q  [NUM_BALLS];
    logic [9:0] y_q  [NUM_BALLS];
    logic       vx_q [NUM_BALLS];
    logic       vy_q [NUM_BALLS];

    logic [9:0] wx_q, wy_q;
    logic       wvx_q, wvy_q;
    logic [9:0] nx, ny;
    logic       nvx, nvy;

    logic [9:0] rd_x_w, rd_y_w;

    assign trig = v_sync_q & ~bus.v_sync;

    always_ff @(posedge clk_50mhz or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            v_sync_q  <= 1'b1;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            v_sync_q  <= bus.v_sync;
            overrun_q <= overrun_q | (trig & (state_q != S_IDLE));
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        busy_w  = 1'b0;
        done_w  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (trig && !bus.pause) begin
                    state_d = S_READ;
                    cnt_d   = '0;
                end
            end
            S_READ: begin
                busy_w  = 1'b1;
                state_d = S_STEP;
            end
            S_STEP: begin
                busy_w  = 1'b1;
                state_d = S_WRITE;
            end
            S_WRITE: begin
                busy_w = 1'b1;
                if (cnt_q == c_last) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                    state_d = S_READ;
                end
            end
            S_DONE: begin
                done_w  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Bounce decisions look at the position before this frame's step.
    always_comb begin
        nx  = wvx_q ? (wx_q + c_speed) : (wx_q - c_speed);
        ny  = wvy_q ? (wy_q + c_speed) : (wy_q - c_speed);
        nvx = (wx_q == c_speed) ? 1'b1 : ((wx_q == c_x_max) ? 1'b0 : wvx_q);
        nvy = (wy_q == c_speed) ? 1'b1 : ((wy_q == c_y_max) ? 1'b0 : wvy_q);
    end

    always_ff @(posedge clk_50mhz or negedge reset_n) begin
        if (!reset_n) begin
            wx_q  <= '0;
            wy_q  <= '0;
            wvx_q <= 1'b0;
            wvy_q <= 1'b0;
            for (int i = 0; i < NUM_BALLS; i++) begin
                x_q[i]  <= 10'(BALL_SPEED * (6 + 8 * i));
                y_q[i]  <= 10'(BALL_SPEED * (4 + 10 * i));
                vx_q[i] <= 1'b1;
                vy_q[i] <= 1'b1;
            end
        end else begin
            case (state_q)
                S_READ: begin
                    wx_q  <= x_q[cnt_q];
                    wy_q  <= y_q[cnt_q];
                    wvx_q <= vx_q[cnt_q];
                    wvy_q <= vy_q[cnt_q];
                end
                S_STEP: begin
                    wx_q  <= nx;
                    wy_q  <= ny;
                    wvx_q <= nvx;
                    wvy_q <= nvy;
                end
                S_WRITE: begin
                    x_q[cnt_q]  <= wx_q;
                    y_q[cnt_q]  <= wy_q;
                    vx_q[cnt_q] <= wvx_q;
                    vy_q[cnt_q] <= wvy_q;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        rd_x_w = '0;
        rd_y_w = '0;
        if (int'(bus.rd_idx) < NUM_BALLS) begin
            rd_x_w = x_q[bus.rd_idx[IDX_W-1:0]];
            rd_y_w = y_q[bus.rd_idx[IDX_W-1:0]];
        end
    end

    assign bus.rd_x       = rd_x_w;
    assign bus.rd_y       = rd_y_w;
    assign bus.busy       = busy_w;
    assign bus.frame_done = done_w;
    assign bus.overrun    = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_ball_motion_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_ball_motion_scheduler
// Description : Directed bench with a frame-level motion model and scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ball_motion_scheduler;

    localparam int NB = 2;
    localparam int BS = 5;
    localparam int SW = 800;
    localparam int SH = 600;
    localparam int BD = 25;

    typedef struct {
        int         idx;
        logic [9:0] x;
        logic [9:0] y;
    } exp_t;

    logic clk_50mhz = 1'b0;
    logic reset_n;
    always #5 clk_50mhz = ~clk_50mhz;

    ball_motion_scheduler_if bus();

    ball_motion_scheduler #(
        .NUM_BALLS     (NB),
        .BALL_SPEED    (BS),
        .SCREEN_WIDTH  (SW),
        .SCREEN_HEIGHT (SH),
        .BALL_DIM      (BD)
    ) dut (
        .clk_50mhz (clk_50mhz),
        .reset_n   (reset_n),
        .bus       (bus)
    );

    int         tests = 0;
    int         fails = 0;
    exp_t       sbq[$];
    logic [9:0] mx [NB];
    logic [9:0] my [NB];
    bit         mvx[NB];
    bit         mvy[NB];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_50mhz);
        #1;
    endtask

    task automatic read_ball(input int i, output logic [9:0] x, output logic [9:0] y);
        bus.rd_idx = 3'(i);
        #1;
        x = bus.rd_x;
        y = bus.rd_y;
    endtask

    function automatic void model_reset();
        for (int i = 0; i < NB; i++) begin
            mx[i]  = 10'(BS * (6 + 8 * i));
            my[i]  = 10'(BS * (4 + 10 * i));
            mvx[i] = 1'b1;
            mvy[i] = 1'b1;
        end
    endfunction

    // Advance every ball by one frame and queue the positions the DUT must show.
    function automatic void model_frame_push();
        exp_t e;
        bit   nvx, nvy;
        for (int i = 0; i < NB; i++) begin
            nvx = (int'(mx[i]) == BS) ? 1'b1 : ((int'(mx[i]) == SW - BD - BS) ? 1'b0 : mvx[i]);
            nvy = (int'(my[i]) == BS) ? 1'b1 : ((int'(my[i]) == SH - BD - BS) ? 1'b0 : mvy[i]);
            mx[i]  = mvx[i] ? 10'(int'(mx[i]) + BS) : 10'(int'(mx[i]) - BS);
            my[i]  = mvy[i] ? 10'(int'(my[i]) + BS) : 10'(int'(my[i]) - BS);
            mvx[i] = nvx;
            mvy[i] = nvy;
            e.idx  = i;
            e.x    = mx[i];
            e.y    = my[i];
            sbq.push_back(e);
        end
    endfunction

    task automatic drain_scoreboard();
        exp_t       e;
        logic [9:0] ax, ay;
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            read_ball(e.idx, ax, ay);
            chk($sformatf("ball%0d_x", e.idx), 32'(ax), 32'(e.x));
            chk($sformatf("ball%0d_y", e.idx), 32'(ay), 32'(e.y));
        end
        bus.rd_idx = 3'd0;
    endtask

    // One v_sync fall; optionally a second fall two cycles after E0.
    task automatic run_frame(input bit inject);
        int         k;
        int         busy_cnt;
        bit         seen;
        logic [9:0] ox;
        ox         = mx[0];
        bus.rd_idx = 3'd0;
        bus.v_sync = 1'b0;
        tick();
        model_frame_push();
        bus.v_sync = 1'b1;
        k        = 0;
        busy_cnt = 0;
        seen     = 1'b0;
        while (!seen && k < 40) begin
            if (bus.busy === 1'b1) busy_cnt++;
            chk("ball0_x_in_sweep", 32'(bus.rd_x), (k >= 3) ? 32'(mx[0]) : 32'(ox));
            if (bus.frame_done === 1'b1) begin
                seen = 1'b1;
            end else begin
                if (inject && k == 1) bus.v_sync = 1'b0;
                if (inject && k == 2) bus.v_sync = 1'b1;
                tick();
                k++;
            end
        end
        chk("frame_done_seen", 32'(seen), 32'd1);
        chk("frame_done_latency", 32'(k), 32'(3 * NB));
        chk("busy_cycles", 32'(busy_cnt), 32'(3 * NB));
        chk("busy_at_done", 32'(bus.busy), 32'd0);
        tick();
        chk("frame_done_width", 32'(bus.frame_done), 32'd0);
        drain_scoreboard();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [9:0] ax, ay;
        int         hits;

        reset_n    = 1'b0;
        bus.v_sync = 1'b1;
        bus.pause  = 1'b0;
        bus.rd_idx = 3'd0;
        model_reset();
        tick();
        tick();
        reset_n = 1'b1;
        tick();

        // Reset state
        read_ball(0, ax, ay);
        chk("rst_ball0_x", 32'(ax), 32'd30);
        chk("rst_ball0_y", 32'(ay), 32'd20);
        read_ball(1, ax, ay);
        chk("rst_ball1_x", 32'(ax), 32'd70);
        chk("rst_ball1_y", 32'(ay), 32'd70);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_overrun", 32'(bus.overrun), 32'd0);
        chk("rst_frame_done", 32'(bus.frame_done), 32'd0);
        tick();
        read_ball(2, ax, ay);
        chk("oob2_x", 32'(ax), 32'd0);
        chk("oob2_y", 32'(ay), 32'd0);
        read_ball(7, ax, ay);
        chk("oob7_x", 32'(ax), 32'd0);
        chk("oob7_y", 32'(ay), 32'd0);
        bus.rd_idx = 3'd0;
        tick();

        // First frame
        run_frame(1'b0);
        read_ball(0, ax, ay);
        chk("f1_ball0_x", 32'(ax), 32'd35);
        chk("f1_ball0_y", 32'(ay), 32'd25);
        read_ball(1, ax, ay);
        chk("f1_ball1_x", 32'(ax), 32'd75);
        chk("f1_ball1_y", 32'(ay), 32'd75);
        bus.rd_idx = 3'd0;

        // Long run through right and bottom bounces
        for (int f = 2; f <= 150; f++) begin
            run_frame(1'b0);
            read_ball(0, ax, ay);
            if (f == 110) chk("y_reach_570", 32'(ay), 32'd570);
            if (f == 111) chk("y_bounce_575", 32'(ay), 32'd575);
            if (f == 112) chk("y_back_570", 32'(ay), 32'd570);
            if (f == 148) chk("x_reach_770", 32'(ax), 32'd770);
            if (f == 149) chk("x_bounce_775", 32'(ax), 32'd775);
            if (f == 150) chk("x_back_770", 32'(ax), 32'd770);
            bus.rd_idx = 3'd0;
        end

        // Paused frame: nothing moves, no activity
        tick();
        bus.pause  = 1'b1;
        bus.v_sync = 1'b0;
        tick();
        bus.v_sync = 1'b1;
        hits = 0;
        for (int c = 0; c < 10; c++) begin
            if (bus.busy !== 1'b0 || bus.frame_done !== 1'b0) hits++;
            tick();
        end
        bus.pause = 1'b0;
        chk("pause_activity", 32'(hits), 32'd0);
        for (int i = 0; i < NB; i++) begin
            read_ball(i, ax, ay);
            chk("pause_x", 32'(ax), 32'(mx[i]));
            chk("pause_y", 32'(ay), 32'(my[i]));
        end
        bus.rd_idx = 3'd0;
        tick();

        // Trigger during a sweep
        chk("pre_overrun", 32'(bus.overrun), 32'd0);
        run_frame(1'b1);
        chk("overrun_set", 32'(bus.overrun), 32'd1);
        for (int c = 0; c < 5; c++) tick();
        chk("overrun_sticky", 32'(bus.overrun), 32'd1);

        // Reset in the middle of a sweep
        bus.v_sync = 1'b0;
        tick();
        bus.v_sync = 1'b1;
        for (int c = 0; c < 4; c++) tick();
        chk("mid_busy_before_rst", 32'(bus.busy), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(bus.busy), 32'd0);
        chk("mid_rst_overrun", 32'(bus.overrun), 32'd0);
        model_reset();
        sbq.delete();
        read_ball(0, ax, ay);
        chk("mid_rst_ball0_x", 32'(ax), 32'd30);
        chk("mid_rst_ball0_y", 32'(ay), 32'd20);
        read_ball(1, ax, ay);
        chk("mid_rst_ball1_x", 32'(ax), 32'd70);
        chk("mid_rst_ball1_y", 32'(ay), 32'd70);
        bus.rd_idx = 3'd0;
        reset_n    = 1'b1;
        tick();
        tick();
        run_frame(1'b0);
        chk("post_rst_overrun", 32'(bus.overrun), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
